bo_seq_alu: RTL and testbench
=============================

// Module: bo_seq_alu
// PURPOSE
//  Self-sequenced ones'-complement (обратный код) operation block for N-bit signed operands.
//  Folds the operation block and its control FSM into one unit: add, subtract, shift-add multiply.
//  Results are 2N-bit ones'-complement with end-around carry, negative zero normalised to +0,
//  and a registered result flag.
//  Driven by a start/busy/done handshake from the processor control unit; replaces external y-vector sequencing.
// PARAMETERS
//  N     4   operand width, sign included; N >= 3
//  CW    clog2(N)   iteration counter width, derived, not overridable
// PORTS
//  clk      in   1     clock, all state on rising edge
//  rst_n    in   1     synchronous active-low reset
//  start    in   1     request; sampled only while busy=0
//  op       in   2     00 add a+b, 01 sub a-b, 10 mul a*b, 11 MAC (see CONFIGURATION)
//  a        in   N     first operand, ones'-complement
//  b        in   N     second operand, ones'-complement
//  rr       out  2N    result, ones'-complement, sign-extended
//  priznak  out  2     00 zero, 01 positive, 10 negative, 11 overflow
//  busy     out  1     operation in progress
//  done     out  1     1-cycle pulse: rr/priznak valid
//  err      out  1     1-cycle pulse with done: illegal op, rr/priznak unchanged
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; rr=0, priznak=00, busy=0, done=0, err=0; counters cleared.
//   Reset overrides any state, including mid-multiply; the aborted result is discarded.
//  Accept: edge with state=IDLE & start=1 latches a,b,op into RA,RB,OP; busy=1 from that edge.
//   start while busy=1 is ignored, with no queueing.
//  FSM: IDLE -> EXEC -> NORM -> DONE -> IDLE.
//   EXEC: add/sub take 1 cycle; mul takes N-1 cycles (counter N-2 down to 0).
//   DONE: done=1 for exactly one cycle, busy=0 in DONE.
//   start in DONE is ignored; IDLE is always visited.
//  Latency: done is high after edge c+2, counting the accept edge as edge 0.
//   add/sub c=1 gives done at edge 3; mul c=N-1 gives done at edge N+1.
//  add/sub: both operands are sign-extended to 2N bits; sub uses ~b.
//   Sum uses end-around carry (carry-out added into LSB). No overflow is possible.
//  mul: magnitudes |a|,|b| are N-1 bits (invert if sign=1).
//   Shift-add over multiplier bits MSB-first: each EXEC cycle P = 2P + (bit ? |a| : 0).
//   Sign = a[N-1]^b[N-1]. In NORM, P is inverted if sign=1.
//  NORM: if the 2N-bit result is all-ones (-0), rr is loaded with 0.
//   priznak is computed from the normalised rr: 00 if rr==0, 10 if rr[2N-1], else 01.
//  rr and priznak change only at the NORM->DONE edge.
//   They hold until the next completed operation or reset.
//  Illegal op (op=11 without MAC_EN): EXEC/NORM are skipped (IDLE->DONE), so done and err are high at edge 2.
//   rr and priznak are unchanged.
// CONFIGURATION
//  MAC_EN defined: op=11 computes rr = rr_old + a*b.
//   The product is formed as for mul, then added to rr_old in NORM with 2N-bit end-around carry (NORM 2 cycles, done at edge N+2).
//   Overflow when the operand signs are equal and the result sign differs: rr takes the wrapped value, priznak=11.
//   -0 is normalised before the overflow check.
//  MAC_EN undefined: op=11 is illegal and handled as above. No accumulate adder is synthesised.
// TESTING  (N=4 unless noted)
//  add a=0011 b=1101 (3+(-2)) -> done at edge 3, rr=00000001, priznak=01, err=0
//  sub a=0011 b=1101 (3-(-2)) -> rr=00000101, priznak=01; add a=1110 b=0001 (-0) -> rr=00000000, priznak=00
//  mul a=0011 b=1101 -> done at edge 5, rr=11111001 (-6), priznak=10; a=1000 b=0111 -> rr=11001110 (-49)
//  mul a=0000 b=1100 -> rr=00000000 (no -0), priznak=00; a=0111 b=0111 -> rr=00110001, priznak=01
//  start re-pulsed while busy -> ignored, one done only; rst_n=0 in 2nd EXEC cycle of mul -> next cycle IDLE, all outputs 0
//  op=11: no MAC_EN -> done=err=1 at edge 2, rr unchanged; MAC_EN, rr=00000001, a=b=0011 -> rr=00001010, priznak=01

Source files
------------

// File: rtl/bo_seq_alu.sv
// rtl/bo_seq_alu.sv - self-sequenced ones'-complement add/sub/mul block with start/busy/done handshake
// Optional multiply-accumulate on op=11 is enabled by defining MAC_EN.
module bo_seq_alu #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] rr,
   output logic [1:0]     priznak,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam int W  = 2 * N;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_INIT = CW'(N - 2);
`ifdef MAC_EN
   localparam bit MAC_BUILD = 1'b1;
`else
   localparam bit MAC_BUILD = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_NORM, S_DONE} state_t;

   state_t        state_q;
   logic [N-1:0]  ra_q, rb_q;
   logic [1:0]    op_q;
   logic [W-1:0]  p_q;
   logic [CW-1:0] cnt_q;
   logic          ill_wait_q;
   logic [W-1:0]  rr_q;
   logic [1:0]    priznak_q;
   logic          busy_q, done_q, err_q;
`ifdef MAC_EN
   logic          norm2_q;
`endif

   function automatic logic [W-1:0] eac_add(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
   endfunction

   function automatic logic [1:0] flag_of(input logic [W-1:0] x);
      return (x == '0) ? 2'b00 : (x[W-1] ? 2'b10 : 2'b01);
   endfunction

   logic [N-1:0] b_eff;
   logic [W-1:0] addsub_d;
   logic [N-2:0] mag_a, mag_b;
   logic [N-1:0] mag_b_ext;
   logic [W-1:0] mul_step_d;
   logic [W-1:0] mul_res, res_raw, res_norm;

   always_comb begin
      b_eff      = op_q[0] ? ~rb_q : rb_q;
      addsub_d   = eac_add({{N{ra_q[N-1]}}, ra_q}, {{N{b_eff[N-1]}}, b_eff});
      mag_a      = ra_q[N-1] ? ~ra_q[N-2:0] : ra_q[N-2:0];
      mag_b      = rb_q[N-1] ? ~rb_q[N-2:0] : rb_q[N-2:0];
      mag_b_ext  = {1'b0, mag_b};
      mul_step_d = {p_q[W-2:0], 1'b0} + (mag_b_ext[cnt_q] ? {{(N+1){1'b0}}, mag_a} : '0);
      mul_res    = (ra_q[N-1] ^ rb_q[N-1]) ? ~p_q : p_q;
      res_raw    = op_q[1] ? mul_res : p_q;
      res_norm   = (&res_raw) ? '0 : res_raw;
   end

`ifdef MAC_EN
   logic [W-1:0] mac_raw, mac_norm;
   logic         mac_ovf;

   // In the second NORM cycle p_q holds the signed, normalised product.
   always_comb begin
      mac_raw  = eac_add(rr_q, p_q);
      mac_norm = (&mac_raw) ? '0 : mac_raw;
      mac_ovf  = (rr_q[W-1] == p_q[W-1]) && (mac_norm[W-1] != rr_q[W-1]);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ra_q       <= '0;
         rb_q       <= '0;
         op_q       <= '0;
         p_q        <= '0;
         cnt_q      <= '0;
         ill_wait_q <= 1'b0;
         rr_q       <= '0;
         priznak_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef MAC_EN
         norm2_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!busy_q) begin
                  if (start) begin
                     ra_q       <= a;
                     rb_q       <= b;
                     op_q       <= op;
                     p_q        <= '0;
                     cnt_q      <= CNT_INIT;
                     busy_q     <= 1'b1;
                     ill_wait_q <= (op == 2'b11) && !MAC_BUILD;
                  end
               // An illegal op spends one decode cycle before reporting.
               end else if (ill_wait_q) begin
                  ill_wait_q <= 1'b0;
               end else if ((op_q == 2'b11) && !MAC_BUILD) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!op_q[1]) begin
                  p_q     <= addsub_d;
                  state_q <= S_NORM;
               end else begin
                  p_q <= mul_step_d;
                  if (cnt_q == '0) state_q <= S_NORM;
                  else             cnt_q   <= cnt_q - CW'(1);
               end
            end
            S_NORM: begin
`ifdef MAC_EN
               if (op_q == 2'b11) begin
                  if (!norm2_q) begin
                     p_q     <= res_norm;
                     norm2_q <= 1'b1;
                  end else begin
                     rr_q      <= mac_norm;
                     priznak_q <= mac_ovf ? 2'b11 : flag_of(mac_norm);
                     norm2_q   <= 1'b0;
                     state_q   <= S_DONE;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end else
`endif
               begin
                  rr_q      <= res_norm;
                  priznak_q <= flag_of(res_norm);
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rr      = rr_q;
   assign priznak = priznak_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bo_seq_alu.sv
// tb/tb_bo_seq_alu.sv - scoreboard bench for bo_seq_alu against an integer-arithmetic reference model
module tb_bo_seq_alu;

   localparam int N = 4;
   localparam int W = 2 * N;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op = '0;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic [W-1:0]   rr;
   logic [1:0]     priznak;
   logic           busy, done, err;

   bo_seq_alu #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .rr(rr), .priznak(priznak), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] rr;
      logic [1:0]   pr;
      logic         err;
      int           acc;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   logic [W-1:0] rr_m = '0;
   logic [1:0]   pr_m = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int val_w(input logic [W-1:0] x);
      logic [W-1:0] t;
      t = ~x;
      return x[W-1] ? -int'(t) : int'(x);
   endfunction

   function automatic int val_n(input logic [N-1:0] x);
      return val_w({{N{x[N-1]}}, x});
   endfunction

   function automatic logic [W-1:0] enc(input int v);
      logic [W-1:0] m;
      m = W'(v < 0 ? -v : v);
      return (v < 0) ? ~m : m;
   endfunction

   function automatic logic [1:0] priz(input int v);
      return (v == 0) ? 2'b00 : ((v < 0) ? 2'b10 : 2'b01);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("rr", 32'(rr), 32'(e.rr));
            check("priznak", 32'(priznak), 32'(e.pr));
            check("err", 32'(err), 32'(e.err));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("busy_in_done", 32'(busy), 32'(0));
         end
      end
   end

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done within 40 cycles");
         sb.delete();
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input bit repulse, input bit start_in_done);
      exp_t e;
      int   r;
      int   lim;
      @(negedge clk);
      op = o; a = xa; b = xb; start = 1'b1;
      e.acc = cyc + 1;
      e.err = 1'b0;
      r = 0;
      case (o)
         2'b00: begin r = val_n(xa) + val_n(xb); e.lat = 3; end
         2'b01: begin r = val_n(xa) - val_n(xb); e.lat = 3; end
         2'b10: begin r = val_n(xa) * val_n(xb); e.lat = N + 1; end
         default: begin
`ifdef MAC_EN
            r = val_w(rr_m) + val_n(xa) * val_n(xb);
            e.lat = N + 2;
`else
            e.err = 1'b1;
            e.lat = 2;
`endif
         end
      endcase
      if (e.err) begin
         e.rr = rr_m;
         e.pr = pr_m;
      end else begin
         lim = 2 ** (W - 1) - 1;
         if (r > lim) begin
            e.rr = enc(r - (2 * lim + 1)); e.pr = 2'b11;
         end else if (r < -lim) begin
            e.rr = enc(r + (2 * lim + 1)); e.pr = 2'b11;
         end else begin
            e.rr = enc(r); e.pr = priz(r);
         end
      end
      rr_m = e.rr;
      pr_m = e.pr;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'(1));
      if (repulse) begin
         @(negedge clk);
         start = 1'b1; a = ~xa; b = ~xb;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
      if (start_in_done) begin
         start = 1'b1; op = 2'b00; a = 4'b0001; b = 4'b0001;
         @(negedge clk);
         start = 1'b0;
         check("start_in_done_ignored", 32'(busy), 32'(0));
      end
      if (repulse || start_in_done) begin
         repeat (8) @(negedge clk);
         check("single_done", 32'(sb.size()), 32'(0));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_rr", 32'(rr), 32'(0));
      check("rst_priznak", 32'(priznak), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      rst_n = 1'b1;

      issue(2'b00, 4'b0011, 4'b1101, 1'b0, 1'b0);
      issue(2'b01, 4'b0011, 4'b1101, 1'b0, 1'b0);
      issue(2'b00, 4'b1110, 4'b0001, 1'b0, 1'b0);
      issue(2'b10, 4'b0011, 4'b1101, 1'b0, 1'b0);
      issue(2'b10, 4'b1000, 4'b0111, 1'b0, 1'b0);
      issue(2'b10, 4'b0000, 4'b1100, 1'b0, 1'b0);
      issue(2'b10, 4'b0111, 4'b0111, 1'b0, 1'b0);
      issue(2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0);
      issue(2'b11, 4'b0011, 4'b0011, 1'b0, 1'b0);
      issue(2'b00, 4'b0010, 4'b0011, 1'b1, 1'b0);
      issue(2'b10, 4'b0101, 4'b1010, 1'b1, 1'b0);
      issue(2'b01, 4'b0101, 4'b0010, 1'b0, 1'b1);

      // Reset during the second EXEC cycle of a multiply.
      @(negedge clk);
      op = 2'b10; a = 4'b0111; b = 4'b0111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_rr", 32'(rr), 32'(0));
      check("midrst_priznak", 32'(priznak), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_done", 32'(done), 32'(0));
      check("midrst_err", 32'(err), 32'(0));
      rst_n = 1'b1;
      rr_m = '0;
      pr_m = '0;
      repeat (6) @(negedge clk);
      check("midrst_no_done", 32'(done), 32'(0));

      repeat (150) issue(2'($urandom_range(0, 3)), N'($urandom), N'($urandom), 1'b0, 1'b0);

      repeat (6) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
